// File: rtl/vga_pkg.sv
// VGA mode constants and shared types for the sync decoder and the timing generator.
package vga_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned H_FP        = 16;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BP        = 48;
  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned V_FP        = 10;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BP        = 33;
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } sync_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Increment that sticks at all-ones so runaway counters never wrap.
  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_edge_det.sv
// Two-flop sampler with a falling-edge pulse (sync signals are active low).
module vga_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall_c
);

  logic q;
  logic qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= 1'b0;
      qq <= 1'b0;
    end else begin
      q  <= d;
      qq <= q;
    end
  end

  assign fall_c = qq & ~q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: pixel coordinates, data enable, timing checks and lock.
// Optional frame checksum outputs (frame_sum, sum_valid) are built when VGA_FRAME_CHECKSUM_EN is defined.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP        = vga_pkg::H_FP,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP        = vga_pkg::V_FP,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_pkg::V_BP,
  parameter int unsigned LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
  input  logic            vgaclk,
  input  logic            rst_n,
  input  logic            hsync,
  input  logic            vsync,
  input  logic [3:0]      red,
  input  logic [3:0]      green,
  input  logic [3:0]      blue,
  output vga_pkg::coord_t x,
  output vga_pkg::coord_t y,
  output logic            de,
  output logic [3:0]      pix_r,
  output logic [3:0]      pix_g,
  output logic [3:0]      pix_b,
  output logic            frame_start,
  output logic            locked,
  output logic            sync_err
`ifdef VGA_FRAME_CHECKSUM_EN
  ,
  output logic [15:0]     frame_sum,
  output logic            sum_valid
`endif
);

  import vga_pkg::*;

  localparam int unsigned LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned GOOD_W    = 3;

  typedef logic [GOOD_W-1:0] good_t;

  localparam coord_t LINE_LAST  = coord_t'(LINE_LEN - 1);
  localparam coord_t FRAME_LAST = coord_t'(FRAME_LEN - 1);
  localparam coord_t H_BEGIN    = coord_t'(H_SYNC + H_BP);
  localparam coord_t H_END      = coord_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam coord_t V_BEGIN    = coord_t'(V_SYNC + V_BP);
  localparam coord_t V_END      = coord_t'(V_SYNC + V_BP + V_ACTIVE);
  localparam coord_t CNT_MAX    = '1;
  localparam good_t  LOCK_GOOD  = good_t'(LOCK_FRAMES);

  logic        line_ev_c;
  logic        frame_ev_c;
  rgb_t        rgb_q;
  coord_t      hcnt_r;
  coord_t      vcnt_r;
  coord_t      hcnt_c;
  coord_t      vcnt_c;
  logic        vs_pending;
  logic        h_valid;
  logic        frame_hit_c;
  logic        sat_err_c;
  logic        line_err_c;
  logic        frame_err_c;
  logic        err_c;
  logic        in_win_c;
  sync_state_t state;
  sync_state_t state_d;
  good_t       good_cnt;
  good_t       good_d;
  logic        frame_bad;
  logic        frame_bad_d;

  vga_edge_det u_hs_edge (.clk(vgaclk), .rst_n(rst_n), .d(hsync), .fall_c(line_ev_c));
  vga_edge_det u_vs_edge (.clk(vgaclk), .rst_n(rst_n), .d(vsync), .fall_c(frame_ev_c));

  // Counters are evaluated for the pixel currently held in rgb_q.
  always_comb begin
    frame_hit_c = line_ev_c & (vs_pending | frame_ev_c);
    hcnt_c      = line_ev_c ? '0 : sat_inc(hcnt_r);
    vcnt_c      = vcnt_r;
    if (frame_hit_c) begin
      vcnt_c = '0;
    end else if (line_ev_c) begin
      vcnt_c = sat_inc(vcnt_r);
    end
    sat_err_c   = !line_ev_c && (hcnt_c == CNT_MAX) && (hcnt_r != CNT_MAX);
    line_err_c  = line_ev_c && h_valid && (hcnt_r != LINE_LAST);
    frame_err_c = frame_hit_c && (state != SEARCH) && (vcnt_r != FRAME_LAST);
    err_c       = sat_err_c | line_err_c | frame_err_c;
    in_win_c    = (hcnt_c >= H_BEGIN) && (hcnt_c < H_END) &&
                  (vcnt_c >= V_BEGIN) && (vcnt_c < V_END);
  end

  // Lock tracking: a frame counts as good only if no error occurred anywhere in it.
  always_comb begin
    state_d     = state;
    good_d      = good_cnt;
    frame_bad_d = frame_bad;
    unique case (state)
      SEARCH: begin
        if (frame_hit_c) begin
          state_d     = TRACK;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end
      end
      TRACK: begin
        if (frame_hit_c) begin
          frame_bad_d = 1'b0;
          if (err_c || frame_bad) begin
            good_d = '0;
          end else if (good_cnt + good_t'(1) == LOCK_GOOD) begin
            good_d  = LOCK_GOOD;
            state_d = LOCKED;
          end else begin
            good_d = good_cnt + good_t'(1);
          end
        end else if (err_c) begin
          good_d      = '0;
          frame_bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (err_c) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q      <= '0;
      hcnt_r     <= '0;
      vcnt_r     <= '0;
      vs_pending <= 1'b0;
      h_valid    <= 1'b0;
      state      <= SEARCH;
      good_cnt   <= '0;
      frame_bad  <= 1'b0;
    end else begin
      rgb_q     <= '{r: red, g: green, b: blue};
      hcnt_r    <= hcnt_c;
      vcnt_r    <= vcnt_c;
      state     <= state_d;
      good_cnt  <= good_d;
      frame_bad <= frame_bad_d;
      if (frame_hit_c) begin
        vs_pending <= 1'b0;
      end else if (frame_ev_c) begin
        vs_pending <= 1'b1;
      end
      // After saturation the next line length is meaningless, so skip its check.
      if (line_ev_c) begin
        h_valid <= 1'b1;
      end else if (sat_err_c) begin
        h_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      de          <= in_win_c && (state == LOCKED);
      pix_r       <= rgb_q.r;
      pix_g       <= rgb_q.g;
      pix_b       <= rgb_q.b;
      frame_start <= frame_hit_c;
      locked      <= (state == LOCKED);
      sync_err    <= err_c;
      if (in_win_c) begin
        x <= hcnt_c - H_BEGIN;
        y <= vcnt_c - V_BEGIN;
      end
    end
  end

`ifdef VGA_FRAME_CHECKSUM_EN
  logic [15:0] sum_acc;
  logic [15:0] sum_acc_c;

  assign sum_acc_c = de ? sum_acc + 16'({pix_r, pix_g, pix_b}) : sum_acc;

  // Frame boundary hands the running sum off in the same cycle frame_start is registered.
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc   <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else if (frame_hit_c) begin
      frame_sum <= sum_acc_c;
      sum_valid <= 1'b1;
      sum_acc   <= '0;
    end else begin
      sum_valid <= 1'b0;
      sum_acc   <= sum_acc_c;
    end
  end
`endif

endmodule
